arbitro_pop_rr: RTL and testbench

- Upstream neighbour of the pop counter stage: selects one of 4 input FIFOs per cycle with round-robin arbitration.
- Pops the selected FIFO and pushes its head word into the downstream FIFO chosen by the word's destination field.
- Generates pop, pop_0..pop_3 and IDLE, which the counter stage consumes directly.
- Input FIFOs are first-word-fall-through: the head word is valid whenever the FIFO is not empty.

---
 rtl/arbitro_pop_rr.sv | 115 +++++++++++
 tb/tb_arbitro_pop_rr.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_pop_rr.sv
// arbitro_pop_rr: picks one of four first-word-fall-through input FIFOs per
// cycle, pops it, and forwards its head word (registered, latency 1) as a
// one-hot push into the downstream FIFO named by the word's destination field.
// Arbitration is round-robin by default; defining ARB_STRICT_PRIO_EN switches
// to fixed priority (FIFO 0 highest) and removes the round-robin pointer.
module arbitro_pop_rr #(
    parameter int DATA_WIDTH = 6,
    parameter int INDEX      = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [3:0]                i_empty,
    input  logic [4*DATA_WIDTH-1:0]   i_data_in,
    input  logic [3:0]                i_almost_full,
    output logic                      o_pop_0,
    output logic                      o_pop_1,
    output logic                      o_pop_2,
    output logic                      o_pop_3,
    output logic                      o_pop,
    output logic [3:0]                o_push,
    output logic [DATA_WIDTH-1:0]     o_data_out,
    output logic                      o_idle
);

    logic [INDEX-1:0]      w_dest [4];
    logic [3:0]            w_eligible;
    logic [1:0]            w_start;
    logic [1:0]            w_sel;
    logic                  w_grantValid;
    logic [3:0]            w_grant;
    logic [3:0]            w_pop;
    logic [INDEX-1:0]      w_selDest;
    logic [DATA_WIDTH-1:0] w_head;

    logic [3:0]            r_push;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_idle;

`ifdef ARB_STRICT_PRIO_EN
    // Fixed priority: the search always begins at FIFO 0.
    assign w_start = 2'd0;
`else
    logic [1:0]            r_rrPtr;

    // Round-robin pointer moves just past the granted FIFO; holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rrPtr <= 2'd0;
        end else if (w_grantValid) begin
            r_rrPtr <= w_sel + 2'd1;
        end
    end

    assign w_start = r_rrPtr;
`endif

    // A FIFO may be served only if it holds a word and that word's
    // destination still has room for the in-flight push.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_dest[k]     = i_data_in[k*DATA_WIDTH +: INDEX];
            w_eligible[k] = !i_empty[k] && !i_almost_full[w_dest[k]];
        end
    end

    // Priority search from the start index, wrapping 3 -> 0; first hit wins.
    always_comb begin
        logic [1:0] w_idx;
        w_idx        = 2'd0;
        w_sel        = 2'd0;
        w_grantValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = w_start + 2'(i);
            if (!w_grantValid && w_eligible[w_idx]) begin
                w_grantValid = 1'b1;
                w_sel        = w_idx;
            end
        end
        w_grant = w_grantValid ? (4'b0001 << w_sel) : 4'b0000;
    end

    assign w_head    = i_data_in[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_selDest = w_dest[w_sel];

    // Pops are combinational so the FIFO advances in the grant cycle, and
    // are forced low while reset is held.
    assign w_pop   = w_grant & {4{!i_reset}};
    assign o_pop_0 = w_pop[0];
    assign o_pop_1 = w_pop[1];
    assign o_pop_2 = w_pop[2];
    assign o_pop_3 = w_pop[3];
    assign o_pop   = |w_pop;

    // Registers the granted word and its one-hot push, and tracks idleness.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_push <= 4'b0000;
            r_data <= '0;
            r_idle <= 1'b0;
        end else begin
            if (w_grantValid) begin
                r_push <= 4'b0001 << w_selDest;
                r_data <= w_head;
            end else begin
                r_push <= 4'b0000;
            end
            r_idle <= (&i_empty) & ~(|w_pop) & ~(|r_push);
        end
    end

    assign o_push     = r_push;
    assign o_data_out = r_data;
    assign o_idle     = r_idle;

endmodule

// File: tb/tb_arbitro_pop_rr.sv
// tb_arbitro_pop_rr: directed tests of the four-input pop arbiter with
// hand-computed expectations; follows ARB_STRICT_PRIO_EN when defined.
module tb_arbitro_pop_rr;

    logic        clk;
    logic        reset;
    logic [3:0]  empty;
    logic [23:0] dataIn;
    logic [3:0]  almostFull;
    logic        pop0, pop1, pop2, pop3, popAny;
    logic [3:0]  push;
    logic [5:0]  dataOut;
    logic        idle;
    logic [3:0]  pops;

    int checks;
    int failures;

    assign pops = {pop3, pop2, pop1, pop0};

    arbitro_pop_rr #(.DATA_WIDTH(6), .INDEX(2)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_empty       (empty),
        .i_data_in     (dataIn),
        .i_almost_full (almostFull),
        .o_pop_0       (pop0),
        .o_pop_1       (pop1),
        .o_pop_2       (pop2),
        .o_pop_3       (pop3),
        .o_pop         (popAny),
        .o_push        (push),
        .o_data_out    (dataOut),
        .o_idle        (idle)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] packHeads(input logic [5:0] h0, input logic [5:0] h1,
                                              input logic [5:0] h2, input logic [5:0] h3);
        return {h3, h2, h1, h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        empty      = 4'b0000;
        almostFull = 4'b0000;
        dataIn     = packHeads(6'b000001, 6'b000110, 6'b001011, 6'b010000);
        #1;
        checks++;
        if (pops !== 4'b0000 || popAny !== 1'b0) begin
            failures++;
            $display("FAIL reset_pops: got %b/%b expected 0000/0", pops, popAny);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (push !== 4'b0000 || dataOut !== 6'd0 || idle !== 1'b0 || pops !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state: push=%b data=%b idle=%b pops=%b expected 0000/000000/0/0000",
                         push, dataOut, idle, pops);
            end
        end
        empty = 4'b1111;
        reset = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b0 || popAny !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle1: idle=%b pop=%b expected 0/0", idle, popAny);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || push !== 4'b0000 || popAny !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle2: idle=%b push=%b pop=%b expected 1/0000/0", idle, push, popAny);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || push !== 4'b0000 || popAny !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle3: idle=%b push=%b pop=%b expected 1/0000/0", idle, push, popAny);
        end
    endtask

    task automatic test_single();
        dataIn = packHeads(6'b000000, 6'b000000, 6'b000101, 6'b000000);
        empty  = 4'b1011;
        #1;
        checks++;
        if (pops !== 4'b0100 || popAny !== 1'b1) begin
            failures++;
            $display("FAIL single_pop: got %b/%b expected 0100/1", pops, popAny);
        end
        tick();
        empty = 4'b1111;
        checks++;
        if (push !== 4'b0010 || dataOut !== 6'b000101 || idle !== 1'b0) begin
            failures++;
            $display("FAIL single_push: push=%b data=%b idle=%b expected 0010/000101/0", push, dataOut, idle);
        end
        #1;
        checks++;
        if (pops !== 4'b0000) begin
            failures++;
            $display("FAIL single_after_pop: got %b expected 0000", pops);
        end
        tick();
        checks++;
        if (push !== 4'b0000 || dataOut !== 6'b000101) begin
            failures++;
            $display("FAIL single_hold: push=%b data=%b expected 0000/000101", push, dataOut);
        end
    endtask

    task automatic test_wrap();
        int firstK;
        int secondK;
        logic [5:0] heads [4];
        heads[0] = 6'b001100;
        heads[1] = 6'b000000;
        heads[2] = 6'b000000;
        heads[3] = 6'b110010;
`ifdef ARB_STRICT_PRIO_EN
        firstK  = 0;
        secondK = 3;
`else
        firstK  = 3;
        secondK = 0;
`endif
        dataIn = packHeads(heads[0], heads[1], heads[2], heads[3]);
        empty  = 4'b0110;
        #1;
        checks++;
        if (pops !== (4'b0001 << firstK)) begin
            failures++;
            $display("FAIL wrap_first_pop: got %b expected %b", pops, 4'b0001 << firstK);
        end
        tick();
        empty[firstK] = 1'b1;
        checks++;
        if (push !== (4'b0001 << heads[firstK][1:0]) || dataOut !== heads[firstK]) begin
            failures++;
            $display("FAIL wrap_first_push: push=%b data=%b expected %b/%b",
                     push, dataOut, 4'b0001 << heads[firstK][1:0], heads[firstK]);
        end
        #1;
        checks++;
        if (pops !== (4'b0001 << secondK)) begin
            failures++;
            $display("FAIL wrap_second_pop: got %b expected %b", pops, 4'b0001 << secondK);
        end
        tick();
        empty = 4'b1111;
        checks++;
        if (push !== (4'b0001 << heads[secondK][1:0]) || dataOut !== heads[secondK]) begin
            failures++;
            $display("FAIL wrap_second_push: push=%b data=%b expected %b/%b",
                     push, dataOut, 4'b0001 << heads[secondK][1:0], heads[secondK]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        empty  = 4'b1110;
        dataIn = packHeads(6'b000011, 6'b000000, 6'b000000, 6'b000000);
        #1;
        checks++;
        if (pops !== 4'b0001) begin
            failures++;
            $display("FAIL mid_grant_pop: got %b expected 0001", pops);
        end
        tick();
        checks++;
        if (push !== 4'b1000 || dataOut !== 6'b000011) begin
            failures++;
            $display("FAIL mid_grant_push: push=%b data=%b expected 1000/000011", push, dataOut);
        end
        reset  = 1'b1;
        empty  = 4'b0000;
        dataIn = packHeads(6'b101000, 6'b010101, 6'b111110, 6'b000111);
        #1;
        checks++;
        if (pops !== 4'b0000 || popAny !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_pops: got %b/%b expected 0000/0", pops, popAny);
        end
        tick();
        checks++;
        if (push !== 4'b0000 || dataOut !== 6'd0 || idle !== 1'b0 || pops !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_state: push=%b data=%b idle=%b pops=%b expected 0000/000000/0/0000",
                     push, dataOut, idle, pops);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [5:0] heads [4];
        int expK [8];
        heads[0] = 6'b101000;
        heads[1] = 6'b010101;
        heads[2] = 6'b111110;
        heads[3] = 6'b000111;
`ifdef ARB_STRICT_PRIO_EN
        expK = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        expK = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        empty      = 4'b0000;
        almostFull = 4'b0000;
        dataIn     = packHeads(heads[0], heads[1], heads[2], heads[3]);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (pops !== (4'b0001 << expK[i])) begin
                failures++;
                $display("FAIL rr_pop[%0d]: got %b expected %b", i, pops, 4'b0001 << expK[i]);
            end
            if (i > 0) begin
                checks++;
                if (push !== (4'b0001 << heads[expK[i-1]][1:0]) || dataOut !== heads[expK[i-1]]) begin
                    failures++;
                    $display("FAIL rr_push[%0d]: push=%b data=%b expected %b/%b", i, push, dataOut,
                             4'b0001 << heads[expK[i-1]][1:0], heads[expK[i-1]]);
                end
            end
            tick();
        end
        empty = 4'b1111;
        checks++;
        if (push !== (4'b0001 << heads[expK[7]][1:0]) || dataOut !== heads[expK[7]]) begin
            failures++;
            $display("FAIL rr_last_push: push=%b data=%b expected %b/%b", push, dataOut,
                     4'b0001 << heads[expK[7]][1:0], heads[expK[7]]);
        end
        tick();
    endtask

    task automatic test_almost_full();
        dataIn     = packHeads(6'b100011, 6'b001010, 6'b000000, 6'b000000);
        empty      = 4'b1100;
        almostFull = 4'b1000;
        #1;
        checks++;
        if (pops !== 4'b0010) begin
            failures++;
            $display("FAIL af_skip_pop: got %b expected 0010", pops);
        end
        tick();
        empty = 4'b1110;
        checks++;
        if (push !== 4'b0100 || dataOut !== 6'b001010) begin
            failures++;
            $display("FAIL af_skip_push: push=%b data=%b expected 0100/001010", push, dataOut);
        end
        #1;
        checks++;
        if (pops !== 4'b0000 || popAny !== 1'b0) begin
            failures++;
            $display("FAIL af_blocked_pop: got %b/%b expected 0000/0", pops, popAny);
        end
        tick();
        checks++;
        if (push !== 4'b0000 || dataOut !== 6'b001010 || idle !== 1'b0) begin
            failures++;
            $display("FAIL af_blocked_state: push=%b data=%b idle=%b expected 0000/001010/0", push, dataOut, idle);
        end
        almostFull = 4'b0000;
        #1;
        checks++;
        if (pops !== 4'b0001) begin
            failures++;
            $display("FAIL af_release_pop: got %b expected 0001", pops);
        end
        tick();
        empty = 4'b1111;
        checks++;
        if (push !== 4'b1000 || dataOut !== 6'b100011) begin
            failures++;
            $display("FAIL af_release_push: push=%b data=%b expected 1000/100011", push, dataOut);
        end
        tick();
        tick();
        checks++;
        if (idle !== 1'b1 || push !== 4'b0000) begin
            failures++;
            $display("FAIL final_idle: idle=%b push=%b expected 1/0000", idle, push);
        end
    endtask

    // Runs every scenario in order; the pointer state left by one feeds the next.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_wrap();
        test_reset_mid();
        test_round_robin();
        test_almost_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
